strb_delay_gen: RTL and testbench

- Multi-channel successor to the single-bit tapped strobe shifter.
- One strobe input feeds a shared DEPTH-stage shift line; each of N_CH channels taps it at its own programmable delay.
- Each channel works in follow mode (delayed copy of the strobe) or pulse mode (fixed-width pulse on each delayed rising edge).
- Configuration is loaded atomically into shadow registers, and outputs are blanked after any load or reset so stale line contents never produce spurious strobes downstream.

---
 rtl/strb_delay_gen.sv | 117 +++++++++++
 tb/tb_strb_delay_gen.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/strb_delay_gen.sv
// Multi-channel tapped strobe delay: one shared shift line, per-channel tap,
// follow or fixed-width pulse mode, shadow config with post-load output blanking.
module strb_delay_gen #(
  parameter int N_CH  = 4,
  parameter int DEPTH = 64,
  parameter int TAP_W = 6,
  parameter int WID_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    din,
  input  logic                    cfg_load,
  input  logic [N_CH*TAP_W-1:0]   tap_in,
  input  logic [N_CH*WID_W-1:0]   width_in,
  input  logic [N_CH-1:0]         mode_in,
  output logic                    busy,
  output logic [N_CH-1:0]         dout
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BLK_W = $clog2(DEPTH + 1);
  localparam logic [IDX_W-1:0] TAP_MAX    = IDX_W'(DEPTH - 1);
  localparam logic [BLK_W-1:0] BLANK_INIT = BLK_W'(DEPTH);

  logic [DEPTH-1:0] line;

  logic [TAP_W-1:0] tap_q   [N_CH];
  logic [WID_W-1:0] width_q [N_CH];
  logic [N_CH-1:0]  mode_q;

  logic [BLK_W-1:0] blank_cnt;
  logic             blank_now;

  logic [IDX_W-1:0] sel  [N_CH];
  logic [WID_W-1:0] w_m1 [N_CH];
  logic [WID_W-1:0] cnt  [N_CH];
  logic [N_CH-1:0]  tapped;
  logic [N_CH-1:0]  prev;
  logic [N_CH-1:0]  rise;

  // No reset on the line so it maps onto shift-register primitives.
  always_ff @(posedge clk) begin
    line <= {line[DEPTH-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        tap_q[c]   <= '0;
        width_q[c] <= WID_W'(1);
      end
      mode_q <= '0;
    end else if (cfg_load) begin
      for (int c = 0; c < N_CH; c++) begin
        tap_q[c]   <= tap_in[c*TAP_W +: TAP_W];
        width_q[c] <= width_in[c*WID_W +: WID_W];
      end
      mode_q <= mode_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      blank_cnt <= BLANK_INIT;
      busy      <= 1'b1;
    end else if (cfg_load) begin
      blank_cnt <= BLANK_INIT;
      busy      <= 1'b1;
    end else if (blank_cnt != '0) begin
      blank_cnt <= blank_cnt - 1'b1;
      busy      <= (blank_cnt != BLK_W'(1));
    end else begin
      busy      <= 1'b0;
    end
  end

  // A load blanks on its own edge so an in-flight pulse is cut immediately.
  assign blank_now = (blank_cnt != '0) | cfg_load;

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      sel[c] = TAP_MAX;
      if (int'(tap_q[c]) < DEPTH) sel[c] = IDX_W'(tap_q[c]);
      tapped[c] = line[sel[c]];
      rise[c]   = tapped[c] & ~prev[c];
      w_m1[c]   = (width_q[c] == '0) ? '0 : width_q[c] - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < N_CH; c++) begin
        cnt[c] <= '0;
      end
      dout <= '0;
      prev <= '1;
    end else begin
      prev <= tapped;
      for (int c = 0; c < N_CH; c++) begin
        if (blank_now) begin
          dout[c] <= 1'b0;
          cnt[c]  <= '0;
        end else if (!mode_q[c]) begin
          dout[c] <= tapped[c];
        end else if (dout[c]) begin
          // Active pulse: rises are ignored, including on the terminal cycle.
          if (cnt[c] != '0) cnt[c] <= cnt[c] - 1'b1;
          else dout[c] <= 1'b0;
        end else if (rise[c]) begin
          dout[c] <= 1'b1;
          cnt[c]  <= w_m1[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_strb_delay_gen.sv
// Bench for strb_delay_gen: cycle-accurate reference model feeds a scoreboard
// queue; a monitor compares every cycle, plus directed boundary checks.
module tb_strb_delay_gen;
  localparam int N_CH  = 4;
  localparam int DEPTH = 64;
  localparam int TAP_W = 6;
  localparam int WID_W = 8;

  logic                  clk = 1'b0;
  logic                  rst, din, cfg_load;
  logic [N_CH*TAP_W-1:0] tap_in;
  logic [N_CH*WID_W-1:0] width_in;
  logic [N_CH-1:0]       mode_in;
  logic                  busy;
  logic [N_CH-1:0]       dout;

  strb_delay_gen #(.N_CH(N_CH), .DEPTH(DEPTH), .TAP_W(TAP_W), .WID_W(WID_W)) dut (
    .clk(clk), .rst(rst), .din(din), .cfg_load(cfg_load), .tap_in(tap_in),
    .width_in(width_in), .mode_in(mode_in), .busy(busy), .dout(dout)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {
    logic            busy;
    logic [N_CH-1:0] dout;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   mon_cyc = 0;

  // Reference model: delay line as a history queue, blanking and pulses as
  // absolute edge-index windows.
  int     m_tap[N_CH];
  int     m_wid[N_CH];
  bit     m_mode[N_CH];
  bit     m_prev[N_CH];
  bit     m_dout[N_CH];
  longint m_hi_last[N_CH];
  longint m_blank_end = 0;
  longint m_edge = 0;
  bit     hist[$];

  function automatic void model_edge();
    bit   tp[N_CH];
    bit   blank;
    int   t, w;
    obs_t o;
    m_edge++;
    for (int c = 0; c < N_CH; c++) begin
      t = (m_tap[c] >= DEPTH) ? DEPTH - 1 : m_tap[c];
      tp[c] = hist[t];
    end
    blank = (m_edge - 1 < m_blank_end) || (cfg_load === 1'b1);
    if (rst === 1'b1) begin
      for (int c = 0; c < N_CH; c++) begin
        m_tap[c] = 0; m_wid[c] = 1; m_mode[c] = 0;
        m_dout[c] = 0; m_hi_last[c] = -1; m_prev[c] = 1;
      end
      m_blank_end = m_edge + DEPTH;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (blank) begin
          m_dout[c] = 0;
          m_hi_last[c] = -1;
        end else if (!m_mode[c]) begin
          m_dout[c] = tp[c];
        end else begin
          w = (m_wid[c] == 0) ? 1 : m_wid[c];
          if (tp[c] && !m_prev[c] && m_hi_last[c] < m_edge - 1)
            m_hi_last[c] = m_edge + w - 1;
          m_dout[c] = (m_edge <= m_hi_last[c]);
        end
        m_prev[c] = tp[c];
      end
      if (cfg_load === 1'b1) begin
        for (int c = 0; c < N_CH; c++) begin
          m_tap[c]  = int'(tap_in[c*TAP_W +: TAP_W]);
          m_wid[c]  = int'(width_in[c*WID_W +: WID_W]);
          m_mode[c] = mode_in[c];
        end
        m_blank_end = m_edge + DEPTH;
      end
    end
    hist.push_front(din);
    void'(hist.pop_back());
    o.busy = (m_edge < m_blank_end);
    for (int c = 0; c < N_CH; c++) o.dout[c] = m_dout[c];
    exp_q.push_back(o);
  endfunction

  initial begin
    obs_t o;
    forever begin
      @(posedge clk);
      #1;
      mon_cyc++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow cycle %0d: no expected entry", mon_cyc);
      end else begin
        o = exp_q.pop_front();
        if ({busy, dout} !== o) begin
          errors++;
          $display("FAIL cycle %0d busy/dout: got %b/%b expected %b/%b",
                   mon_cyc, busy, dout, o.busy, o.dout);
        end
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    din = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_ch(input int c, input int tap, input int wid, input bit mode);
    tap_in[c*TAP_W +: TAP_W]   = TAP_W'(tap);
    width_in[c*WID_W +: WID_W] = WID_W'(wid);
    mode_in[c]                 = mode;
  endtask

  task automatic load();
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  initial begin
    int nb, first_hi, hi_cnt, dens;
    int hc[N_CH];
    rst = 1'b1; din = 1'b0; cfg_load = 1'b0;
    tap_in = '0; width_in = '0; mode_in = '0;
    for (int i = 0; i < DEPTH; i++) hist.push_back(1'b0);

    // Reset, then blanking with din toggling every cycle.
    repeat (5) tick();
    rst = 1'b0;
    for (int i = 0; i < 63; i++) begin
      din = ~din;
      tick();
      chk("reset_blank_dout", dout, 0);
    end
    chk("reset_busy_cycle64", busy, 1);
    din = ~din;
    tick();
    chk("reset_busy_release", busy, 0);
    idle(4);

    // Follow/pulse taps, second strobe during an active pulse, terminal-cycle rise.
    set_ch(0, 5, 1, 0); set_ch(1, 0, 1, 0); set_ch(2, 3, 10, 1); set_ch(3, 0, 4, 1);
    load();
    idle(63);
    chk("load_busy_last", busy, 1);
    idle(1);
    chk("load_busy_release", busy, 0);
    idle(3);
    din = 1'b1;
    tick();
    for (int off = 1; off <= 20; off++) begin
      din = (off == 4);
      tick();
      chk("follow_tap5", dout[0], (off == 6 || off == 10));
      chk("follow_tap0", dout[1], (off == 1 || off == 5));
      chk("pulse_w10_no_retrig", dout[2], (off >= 4 && off <= 13));
      chk("pulse_w4_end_rise", dout[3], (off >= 1 && off <= 4));
    end

    // Long high level: width 0, width 4 pulses and follow copies.
    set_ch(2, 3, 0, 1);
    load();
    idle(68);
    for (int c = 0; c < N_CH; c++) hc[c] = 0;
    for (int i = 0; i < 45; i++) begin
      din = (i < 20);
      tick();
      for (int c = 0; c < N_CH; c++) hc[c] += int'(dout[c]);
    end
    chk("long_follow_tap5", hc[0], 20);
    chk("long_follow_tap0", hc[1], 20);
    chk("long_pulse_w0", hc[2], 1);
    chk("long_pulse_w4", hc[3], 4);

    // Load mid-pulse, then a second load 30 cycles into blanking.
    set_ch(2, 3, 10, 1);
    load();
    idle(68);
    din = 1'b1;
    tick();
    din = 1'b0;
    for (int off = 1; off <= 5; off++) tick();
    chk("midpulse_active", dout[2], 1);
    set_ch(2, 10, 10, 1);
    nb = 0;
    load();
    chk("midpulse_cut", dout, 0);
    nb += int'(busy);
    for (int i = 1; i < 30; i++) begin
      tick();
      nb += int'(busy);
    end
    load();
    nb += int'(busy);
    for (int g = 0; g < 200 && busy; g++) begin
      tick();
      nb += int'(busy);
    end
    chk("busy_extended", nb, 94);

    // Reset wins over a simultaneous load.
    for (int c = 0; c < N_CH; c++) set_ch(c, 7, 3, 1);
    rst = 1'b1; cfg_load = 1'b1;
    tick();
    rst = 1'b0; cfg_load = 1'b0;
    idle(63);
    chk("rst_load_busy", busy, 1);
    idle(3);
    din = 1'b1;
    tick();
    din = 1'b0;
    for (int off = 1; off <= 10; off++) begin
      tick();
      chk("rst_defaults_tap0", dout, (off == 1) ? 4'hF : 4'h0);
    end

    // Deepest tap.
    for (int c = 0; c < N_CH; c++) set_ch(c, 63, 1, 0);
    load();
    idle(66);
    din = 1'b1;
    tick();
    din = 1'b0;
    first_hi = -1; hi_cnt = 0;
    for (int off = 1; off <= 72; off++) begin
      tick();
      if (dout[0] && first_hi < 0) first_hi = off;
      hi_cnt += int'(dout[0]);
    end
    chk("tap63_latency", first_hi, 64);
    chk("tap63_width", hi_cnt, 1);

    // Randomized traffic.
    dens = 5;
    for (int i = 0; i < 4000; i++) begin
      if (i % 100 == 0) dens = int'($urandom_range(1, 9));
      din = ($urandom_range(0, 9) < dens);
      cfg_load = ($urandom_range(0, 149) == 0);
      rst = ($urandom_range(0, 1499) == 0);
      if (cfg_load) begin
        for (int c = 0; c < N_CH; c++)
          set_ch(c, int'($urandom_range(0, 63)),
                 ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255)),
                 $urandom_range(0, 1) == 1);
      end
      tick();
    end
    rst = 1'b0; cfg_load = 1'b0;
    idle(2);

    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
